upg_loader: RTL

UPG_LOADER -- requirements
Module: upg_loader

---
 rtl/upg_loader_pkg.sv | 17 +
 rtl/upg_word_packer.sv | 42 ++++
 rtl/upg_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/upg_loader_pkg.sv
// Shared definitions for the upgrade loader and the memory wrappers that
// hand their RAM over to it.
package upg_loader_pkg;

  localparam int UPG_ADR_W     = 14;
  localparam int UPG_MAX_WORDS = 16384;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } upg_state_e;

endpackage

// File: rtl/upg_word_packer.sv
// Assembles four consecutive bytes into a little-endian 32-bit word;
// word_done_o flags the byte that completes a word, in the cycle it arrives.
module upg_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  // clear only rewinds the lane index; the word keeps its value so the
  // caller can still present it while the packer is held clear.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (valid_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = idx_q + 2'd1;
    end
  end

  assign word_done_o = valid_i && !clear_i && (idx_q == 2'd3);
  assign word_o      = word_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/upg_loader.sv
// UART-fed program loader: reads a 16-bit word count followed by that many
// little-endian words and writes them to consecutive RAM addresses from 0.
module upg_loader
  import upg_loader_pkg::*;
#(
  parameter int MAX_WORDS = UPG_MAX_WORDS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic                 upg_wen_o,
  output logic [UPG_ADR_W-1:0] upg_adr_o,
  output logic [31:0]          upg_dat_o,
  output logic                 upg_done_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  upg_state_e           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [UPG_ADR_W-1:0] adr_q, adr_d;
  logic [UPG_ADR_W-1:0] adr_hold_q, adr_hold_d;
  logic [31:0]          dat_hold_q, dat_hold_d;
  logic                 err_q, err_d;

  logic        xfer;
  logic [15:0] len_full;
  logic        pk_valid;
  logic        pk_clear;
  logic [31:0] pk_word;
  logic        pk_done;

  upg_word_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .byte_i      (rx_data_i),
    .valid_i     (pk_valid),
    .clear_i     (pk_clear),
    .word_o      (pk_word),
    .word_done_o (pk_done)
  );

  assign rx_ready_o = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
  assign upg_wen_o  = (state_q == ST_WRITE);
  assign upg_done_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy_o     = !upg_done_o;
  assign err_o      = err_q;

  // Outside WRITE the RAM port shows the last word written.
  assign upg_adr_o = upg_wen_o ? adr_q : adr_hold_q;
  assign upg_dat_o = upg_wen_o ? pk_word : dat_hold_q;

  assign xfer     = rx_valid_i && rx_ready_o;
  assign len_full = {rx_data_i, cnt_q[7:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    adr_hold_d = adr_hold_q;
    dat_hold_d = dat_hold_q;
    err_d      = err_q;
    pk_valid   = rx_valid_i && (state_q == ST_DATA);
    pk_clear   = start_i || (state_q != ST_DATA);

    if (state_q == ST_WRITE) begin
      adr_hold_d = adr_q;
      dat_hold_d = pk_word;
    end

    if (start_i) begin
      // start wins in every state, including a restart mid-session
      state_d = ST_LEN_LO;
      cnt_d   = 16'd0;
      adr_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LEN_LO: begin
          if (xfer) begin
            cnt_d[7:0] = rx_data_i;
            state_d    = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            cnt_d[15:8] = rx_data_i;
            if (len_full == 16'd0) begin
              state_d = ST_DONE;
            end else if ({1'b0, len_full} > MAX_N) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              adr_d   = '0;
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (pk_done) state_d = ST_WRITE;
        end
        ST_WRITE: begin
          // Address only advances when another word follows, so it never wraps.
          if ((16'(adr_q) + 16'd1) == cnt_q) begin
            state_d = ST_DONE;
          end else begin
            adr_d   = adr_q + 1'b1;
            state_d = ST_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      adr_q      <= '0;
      adr_hold_q <= '0;
      dat_hold_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      adr_hold_q <= adr_hold_d;
      dat_hold_q <= dat_hold_d;
      err_q      <= err_d;
    end
  end

endmodule
